mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmit peripheral: the responder on the pipelined core's memory-stage data bus (we/addr/wdata in, rdata out).
- Sits beside data_memory. CPU stores to its address window push bytes into a TX FIFO; a serializer shifts them out as 8N1 frames on a board pin.
- Reads are combinational and side-effect free, matching the data-memory read timing, so the core needs no stall logic.

Parameters:
- BASE, 32'h0000_0400, window base; 16-byte window, BASE[3:0] must be 0.
- DEPTH, 8, FIFO entries; power of two, 2..128.
- CLKDIV_RESET, 16'd104, reset value of the CLKDIV register (clk cycles per bit).

Ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  asynchronous, active-high reset
- we  input  1  store strobe from memory stage (memwrite_m)
- addr  input  32  byte address (aluresult_m); addr[1:0] ignored
- wdata  input  32  store data (wdata_m)
- rdata  output  32  combinational read data; 0 when not hit
- hit  output  1  combinational: addr[31:4]==BASE[31:4]; steers the load-data mux
- tx  output  1  serial line, registered, idle high
- busy  output  1  serializer not IDLE or FIFO not empty

Behaviour:
- Register map (offset addr[3:2]):
  - 0x0 TXDATA. Write pushes wdata[7:0]; read returns 0.
  - 0x4 STATUS, read: [0] full, [1] empty, [2] overflow (sticky), [3] serializer active, [15:8] FIFO level, others 0. Write with wdata[2]=1 clears overflow; other bits ignored.
  - 0x8 CLKDIV. R/W, 16 bits, read zero-extended. A write of 0 stores 1.
  - 0xC reserved. Reads 0, writes ignored.
- Side effects occur only when we & hit, at posedge clk.
- Push into a full FIFO (full = registered level==DEPTH):
  - byte dropped, overflow set next cycle;
  - this holds even if the serializer pops in the same cycle.
- Overflow set and clear in the same cycle: set wins.
- FIFO: circular, read/write pointers wrap modulo DEPTH; level is log2(DEPTH)+1 bits. Simultaneous push (not full) and pop leaves level unchanged.
- Serializer FSM: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head byte into the shift register, latch CLKDIV into the divider, set the baud counter to 0, go to START. tx=0 starts on the same edge as the pop.
  - Every state holds tx for exactly the latched divider value in clk cycles. The baud counter counts 0..div-1, and the bit boundary is at count==div-1.
  - START then DATA: 8 bits, LSB first; a 3-bit counter wraps 7→0 into STOP.
  - STOP: tx=1 for one bit period. At the boundary, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - Frame length = 10*div cycles.
- Latency: a TXDATA write at edge N into an empty FIFO with the serializer IDLE gives tx falling at edge N+1 (pop at N+1).
- A CLKDIV write mid-frame does not affect the current frame; it applies from the next pop.
- Reset, asynchronous and legal at any time including mid-frame:
  - tx=1, FSM IDLE;
  - FIFO empty, pointers 0, overflow 0;
  - CLKDIV=CLKDIV_RESET, counters 0.
  - The frame in flight is abandoned, with no partial stop bit.
- rdata and hit depend only on addr and current state; we does not affect them.

Test Plan:
- Reset, then read STATUS → rdata=32'h0000_0002; tx=1; busy=0; read CLKDIV → 104.
- Write CLKDIV=4, write TXDATA=0x55 at edge N → tx: 0 for cycles N+1..N+4, then 1,0,1,0,1,0,1,0 (4 cycles each), then stop 1 for 4 cycles; busy drops after cycle N+40.
- CLKDIV=2, write 0xA1 then 0x3C back-to-back → second start bit begins exactly 20 cycles after the first; no idle cycles; STATUS level reads 1 between the two pops.
- CLKDIV=1000, write 9 bytes quickly (DEPTH=8, first popped immediately) → 9th accepted, level=8, full=1. A 10th write is dropped and overflow=1. Write STATUS with 0x4 → overflow=0.
- Write CLKDIV=3 mid-frame at CLKDIV=5 → current frame keeps 5-cycle bits; next frame uses 3-cycle bits. Writing CLKDIV=0 reads back 1.
- Assert reset during DATA bit 4 → tx=1 immediately (asynchronously). After release: STATUS=0x2, no residual frame; addr outside window → hit=0, rdata=0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped UART transmitter that answers on the core's memory-stage data
// bus next to data_memory. Stores into the 16-byte window push bytes into a
// small FIFO. A serializer then sends each byte as an 8N1 frame on `tx`.
// Reads are purely combinational and have no side effects. This matches the
// data-memory read timing, so the core never has to stall for this block.
//
// Register map (offset = addr[3:2]):
//   0x0 TXDATA  W: push wdata[7:0]            R: 0
//   0x4 STATUS  R: [0] full [1] empty [2] overflow (sticky)
//                  [3] serializer active [15:8] FIFO level
//               W: wdata[2]=1 clears overflow
//   0x8 CLKDIV  R/W 16 bits (clk cycles per bit), writing 0 stores 1
//   0xC reserved, reads 0, writes ignored
//
// Ports:
//   clk    in   system clock, all state on posedge
//   reset  in   asynchronous active-high reset
//   we     in   store strobe from the memory stage
//   addr   in   byte address (addr[1:0] ignored)
//   wdata  in   store data
//   rdata  out  combinational read data, 0 when the window is not hit
//   hit    out  combinational window decode, steers the load-data mux
//   tx     out  registered serial line, idle high
//   busy   out  serializer not idle or FIFO not empty
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter logic [31:0] BASE         = 32'h0000_0400,
    parameter int          DEPTH        = 8,
    parameter logic [15:0] CLKDIV_RESET = 16'd104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        tx,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CLKDIV = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_ovf;
    logic [15:0]   r_clkdiv;

    // Serializer state
    state_t        r_state;
    logic [7:0]    r_shift;
    logic [15:0]   r_div;
    logic [15:0]   r_baud;
    logic [2:0]    r_bit;
    logic          r_tx;

    // Bus decode
    logic          w_wr;
    logic [1:0]    w_off;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [7:0]    w_head;
    logic          w_unused;

    // Serializer next-state signals
    state_t        w_state_nxt;
    logic          w_pop;
    logic          w_bound;
    logic          w_tx_nxt;
    logic [15:0]   w_baud_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_shift_nxt;
    logic [15:0]   w_div_nxt;

    assign w_unused = ^{addr[1:0], wdata[31:16]};

    assign hit     = (addr[31:4] == BASE[31:4]);
    assign w_wr    = we & hit;
    assign w_off   = addr[3:2];
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    assign w_head  = r_mem[r_rptr];

    // A push into a full FIFO is dropped even when the serializer pops on the
    // same edge: fullness is judged on the registered level only.
    assign w_push    = w_wr && (w_off == OFF_TXDATA) && !w_full;
    assign w_ovf_set = w_wr && (w_off == OFF_TXDATA) && w_full;
    assign w_ovf_clr = w_wr && (w_off == OFF_STATUS) && wdata[2];

    assign w_bound = (r_baud == (r_div - 16'd1));

    assign tx   = r_tx;
    assign busy = (r_state != S_IDLE) || !w_empty;

    // ------------------------------------------------------------------
    // Combinational read port
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (hit) begin
            unique case (w_off)
                OFF_STATUS: begin
                    rdata[0]    = w_full;
                    rdata[1]    = w_empty;
                    rdata[2]    = r_ovf;
                    rdata[3]    = (r_state != S_IDLE);
                    rdata[15:8] = 8'(r_level);
                end
                OFF_CLKDIV: rdata[15:0] = r_clkdiv;
                default:    rdata = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (data only, no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata[7:0];
        end
    end

    // ------------------------------------------------------------------
    // FIFO control, overflow flag and CLKDIV register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_clkdiv <= CLKDIV_RESET;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end

            // Set has priority over a clear on the same edge.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end

            if (w_wr && (w_off == OFF_CLKDIV)) begin
                r_clkdiv <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= CLKDIV_RESET;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Shift register holds payload only; it is reloaded on every pop.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    // ------------------------------------------------------------------
    // Serializer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_div_nxt   = r_div;
        w_pop       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop = 1'b1;
                end
            end
            S_START: begin
                if (w_bound) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bound) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = r_bit + 3'd1;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_tx_nxt = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bound) begin
                    w_baud_nxt = '0;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // A pop loads the next byte and the divider together, so a CLKDIV
        // write only takes effect at the start of the following frame.
        if (w_pop) begin
            w_state_nxt = S_START;
            w_shift_nxt = w_head;
            w_div_nxt   = r_clkdiv;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE     = 32'h0000_0400;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] A_TXDATA = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'd4;
    localparam logic [31:0] A_CLKDIV = BASE + 32'd8;
    localparam logic [31:0] A_RSVD   = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic rec = 1'b0;
    logic tx_log[$];
    logic exp_q[$];

    mmio_uart_tx #(
        .BASE(BASE),
        .DEPTH(DEPTH),
        .CLKDIV_RESET(16'd104)
    ) dut (
        .clk(clk),
        .reset(reset),
        .we(we),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .hit(hit),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Line recorder: one sample of tx per clock, taken 1 ns after the edge.
    always @(posedge clk) begin
        #1;
        if (rec) tx_log.push_back(tx);
    end

    // Reference model: an 8N1 frame is start(0), 8 data bits LSB first,
    // stop(1), each symbol held for d clock cycles.
    function automatic void model_frame(input logic [7:0] b, input int d);
        logic [9:0] sym;
        sym = {1'b1, b, 1'b0};
        for (int s = 0; s < 10; s++)
            for (int c = 0; c < d; c++)
                exp_q.push_back(sym[s]);
    endfunction

    // Bus access: called 1 ns after a rising edge; a write lands on the next edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        we   = 1'b0;
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic start_record();
        tx_log.delete();
        exp_q.delete();
        rec = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h2); end
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        bus_read(A_CLKDIV, d);
        checks++;
        if (d !== 32'd104) begin errors++; $display("FAIL reset_clkdiv: got %0d expected 104", d); end
    endtask

    task automatic test_single_frame();
        int bad;
        @(posedge clk); #1;
        bus_write(A_CLKDIV, 32'd4);
        start_record();
        exp_q.push_back(1'b1);
        model_frame(8'h55, 4);
        exp_q.push_back(1'b1);
        bus_write(A_TXDATA, 32'h55);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL frame55_busy_hold: got %b expected 1", busy); end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL frame55_busy_drop: got %b expected 0", busy); end
        #2;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= tx_log.size() || tx_log[i] !== exp_q[i])) bad = i;
        rec = 1'b0;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL frame55_wave: sample %0d got %b expected %b", bad, tx_log[bad], exp_q[bad]); end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [31:0] d;
        bus_write(A_CLKDIV, 32'd2);
        start_record();
        exp_q.push_back(1'b1);
        model_frame(8'hA1, 2);
        model_frame(8'h3C, 2);
        exp_q.push_back(1'b1);
        bus_write(A_TXDATA, 32'hA1);
        bus_write(A_TXDATA, 32'h3C);
        bus_read(A_STATUS, d);
        checks++;
        if (d[15:8] !== 8'd1) begin errors++; $display("FAIL b2b_level_early: got %0d expected 1", d[15:8]); end
        repeat (10) @(posedge clk);
        bus_read(A_STATUS, d);
        checks++;
        if (d[15:8] !== 8'd1) begin errors++; $display("FAIL b2b_level_mid: got %0d expected 1", d[15:8]); end
        repeat (30) @(posedge clk);
        #2;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= tx_log.size() || tx_log[i] !== exp_q[i])) bad = i;
        rec = 1'b0;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL b2b_wave: sample %0d got %b expected %b", bad, tx_log[bad], exp_q[bad]); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_clkdiv_change();
        int bad;
        logic [7:0] b1, b2;
        logic [31:0] d;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        bus_write(A_CLKDIV, 32'd5);
        start_record();
        exp_q.push_back(1'b1);
        model_frame(b1, 5);
        model_frame(b2, 3);
        exp_q.push_back(1'b1);
        bus_write(A_TXDATA, {24'd0, b1});
        bus_write(A_TXDATA, {24'd0, b2});
        bus_write(A_CLKDIV, 32'd3);
        repeat (79) @(posedge clk);
        #2;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= tx_log.size() || tx_log[i] !== exp_q[i])) bad = i;
        rec = 1'b0;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL clkdiv_change_wave: sample %0d got %b expected %b", bad, tx_log[bad], exp_q[bad]); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL clkdiv_change_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        bus_write(A_CLKDIV, 32'd0);
        bus_read(A_CLKDIV, d);
        checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL clkdiv_zero: got %0d expected 1", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        bus_write(A_CLKDIV, 32'd1000);
        for (int i = 0; i < DEPTH + 1; i++)
            bus_write(A_TXDATA, $urandom);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_0809) begin errors++; $display("FAIL ovf_full_status: got %h expected %h", d, 32'h0809); end
        @(posedge clk); #1;
        bus_write(A_TXDATA, $urandom);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_080D) begin errors++; $display("FAIL ovf_set_status: got %h expected %h", d, 32'h080D); end
        @(posedge clk); #1;
        bus_write(A_STATUS, 32'h0000_0004);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_0809) begin errors++; $display("FAIL ovf_clear_status: got %h expected %h", d, 32'h0809); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL ovf_reset_status: got %h expected %h", d, 32'h2); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        logic [7:0] b;
        logic [31:0] d;
        b = 8'($urandom) & 8'hEF;
        @(posedge clk); #1;
        bus_write(A_CLKDIV, 32'd4);
        bus_write(A_TXDATA, {24'd0, b});
        repeat (22) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL midframe_bit4: got %b expected 0", tx); end
        reset = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midframe_async_tx: got %b expected 1", tx); end
        @(posedge clk); #1;
        reset = 1'b0;
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL midframe_status: got %h expected %h", d, 32'h2); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midframe_busy: got %b expected 0", busy); end
        start_record();
        for (int i = 0; i < 30; i++) exp_q.push_back(1'b1);
        repeat (30) @(posedge clk);
        #2;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= tx_log.size() || tx_log[i] !== exp_q[i])) bad = i;
        rec = 1'b0;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL midframe_residual: sample %0d got %b expected %b", bad, tx_log[bad], exp_q[bad]); end
    endtask

    task automatic test_random();
        int bad, d, k;
        logic [7:0] b;
        logic [31:0] s;
        for (int it = 0; it < 4; it++) begin
            d = $urandom_range(1, 6);
            k = $urandom_range(1, 5);
            bus_write(A_CLKDIV, d);
            start_record();
            exp_q.push_back(1'b1);
            for (int j = 0; j < k; j++) begin
                b = 8'($urandom);
                model_frame(b, d);
                bus_write(A_TXDATA, {24'd0, b});
            end
            exp_q.push_back(1'b1);
            repeat (10 * d * k + 2 - k) @(posedge clk);
            #2;
            bad = -1;
            for (int i = 0; i < exp_q.size(); i++)
                if (bad < 0 && (i >= tx_log.size() || tx_log[i] !== exp_q[i])) bad = i;
            rec = 1'b0;
            checks++;
            if (bad >= 0) begin errors++; $display("FAIL random_wave: iter %0d div %0d bytes %0d sample %0d got %b expected %b", it, d, k, bad, tx_log[bad], exp_q[bad]); end
            bus_read(A_STATUS, s);
            checks++;
            if (s !== 32'h0000_0002) begin errors++; $display("FAIL random_idle_status: iter %0d got %h expected %h", it, s, 32'h2); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_window();
        logic [31:0] d;
        bus_read(32'h0000_0800, d);
        checks++;
        if (hit !== 1'b0 || d !== 32'd0) begin errors++; $display("FAIL window_outside: hit %b rdata %h expected hit 0 rdata 0", hit, d); end
        bus_read(A_RSVD, d);
        checks++;
        if (hit !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL window_reserved: hit %b rdata %h expected hit 1 rdata 0", hit, d); end
        bus_read(A_TXDATA, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL window_txdata_read: got %h expected 0", d); end
        we = 1'b1;
        addr = A_CLKDIV;
        #1;
        checks++;
        if (rdata[15:0] === 16'd0 || hit !== 1'b1) begin errors++; $display("FAIL window_we_independent: hit %b rdata %h expected hit 1 nonzero clkdiv", hit, rdata); end
        we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_clkdiv_change();
        test_overflow();
        test_reset_midframe();
        test_random();
        test_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
